// File: rtl/hazard_ctrl_mc_pkg.sv
// hazard_ctrl_mc_pkg
// Shared constants for the multi-cycle hazard controller: RV32 major opcodes
// that matter for source-register usage, and the controller state encoding.
// No ports (package).

package hazard_ctrl_mc_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_ILOAD = 7'b0000011;
    localparam logic [6:0] OPCODE_IJALR = 7'b1100111;
    localparam logic [6:0] OPCODE_STYPE = 7'b0100011;
    localparam logic [6:0] OPCODE_BTYPE = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        HZ_ST_RUN  = 2'd0,
        HZ_ST_LOAD = 2'd1,
        HZ_ST_MC   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_mc_src_decode.sv
// hazard_src_decode
// Combinational decode of which source registers the ID-stage instruction
// actually reads, so unused rs fields never raise a false load-use stall.
// Ports:
//   opcode   in  7  ID opcode
//   rs1_used out 1  instruction reads rs1
//   rs2_used out 1  instruction reads rs2

module hazard_src_decode
    import hazard_ctrl_mc_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       rs1_used,
    output logic       rs2_used
);

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OPCODE_RTYPE, OPCODE_STYPE, OPCODE_BTYPE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPCODE_ITYPE, OPCODE_ILOAD, OPCODE_IJALR: begin
                rs1_used = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc
// Pipeline hazard controller beside the ID stage. Inserts LOAD_STALL_CYCLES
// bubbles per load-use hazard, freezes the pipe during multi-cycle EX ops,
// flushes on taken jump/branch and kills illegal ID instructions.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state      | meaning
// HZ_ST_RUN  | normal operation
// HZ_ST_LOAD | extra load bubbles remain (stall_cnt = bubbles left)
// HZ_ST_MC   | waiting for ex_mc_done
//
// Ports:
//   clk, rst (sync, active-high)
//   id_rs1/id_rs2/opcode            ID-stage instruction fields
//   ex_rd/ex_load_inst              EX-stage load info
//   ex_mc_start/ex_mc_done          multi-cycle unit handshake
//   jump_branch_taken, invalid_inst redirect / illegal instruction
//   *_pipeline_flush/_en, pc_en     pipeline register controls
//   load_stall, mc_stall            stall status
//   perf_* (HAZARD_PERF_CNT_EN)     CNT_W-bit stall/flush counters

module hazard_ctrl_mc
    import hazard_ctrl_mc_pkg::*;
#(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_load_inst,
    input  logic                  ex_mc_start,
    input  logic                  ex_mc_done,
    input  logic                  jump_branch_taken,
    input  logic                  invalid_inst,
    output logic                  if_id_pipeline_flush,
    output logic                  if_id_pipeline_en,
    output logic                  id_ex_pipeline_flush,
    output logic                  id_ex_pipeline_en,
    output logic                  ex_mem_pipeline_flush,
    output logic                  pc_en,
    output logic                  load_stall,
    output logic                  mc_stall
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0]      perf_load_stall_cyc,
    output logic [CNT_W-1:0]      perf_mc_stall_cyc,
    output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);

    // The first bubble is issued from ST_RUN; the counter holds the rest.
    localparam logic [2:0] LOAD_EXTRA = 3'(LOAD_STALL_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [2:0] stall_cnt_q, stall_cnt_d;
    logic       rs1_used, rs2_used;
    logic       load_hazard;

    hazard_src_decode u_src_decode (
        .opcode   (opcode),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign load_hazard = ex_load_inst && (ex_rd != '0) &&
                         ((rs1_used && id_rs1 == ex_rd) ||
                          (rs2_used && id_rs2 == ex_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_ST_RUN;
            stall_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        if_id_pipeline_flush  = 1'b0;
        if_id_pipeline_en     = 1'b1;
        id_ex_pipeline_flush  = 1'b0;
        id_ex_pipeline_en     = 1'b1;
        ex_mem_pipeline_flush = 1'b0;
        pc_en                 = 1'b1;
        load_stall            = 1'b0;
        mc_stall              = 1'b0;
        state_d               = state_q;
        stall_cnt_d           = stall_cnt_q;

        if (rst) begin
            if_id_pipeline_flush  = 1'b1;
            id_ex_pipeline_flush  = 1'b1;
            ex_mem_pipeline_flush = 1'b1;
            state_d               = HZ_ST_RUN;
            stall_cnt_d           = 3'd0;
        end else if (jump_branch_taken) begin
            // Redirect wins in every state and abandons any pending stall.
            if_id_pipeline_flush = 1'b1;
            if_id_pipeline_en    = 1'b0;
            id_ex_pipeline_flush = 1'b1;
            state_d              = HZ_ST_RUN;
            stall_cnt_d          = 3'd0;
        end else begin
            case (state_q)
                HZ_ST_RUN: begin
                    if (ex_mc_start && !ex_mc_done) begin
                        pc_en                 = 1'b0;
                        if_id_pipeline_en     = 1'b0;
                        id_ex_pipeline_en     = 1'b0;
                        ex_mem_pipeline_flush = 1'b1;
                        mc_stall              = 1'b1;
                        state_d               = HZ_ST_MC;
                    end else if (load_hazard) begin
                        pc_en                = 1'b0;
                        if_id_pipeline_en    = 1'b0;
                        id_ex_pipeline_flush = 1'b1;
                        load_stall           = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d     = HZ_ST_LOAD;
                            stall_cnt_d = LOAD_EXTRA;
                        end
                    end else if (invalid_inst) begin
                        id_ex_pipeline_flush = 1'b1;
                    end
                end
                HZ_ST_LOAD: begin
                    // Bubbles continue regardless of what EX/ID now hold.
                    pc_en                = 1'b0;
                    if_id_pipeline_en    = 1'b0;
                    id_ex_pipeline_flush = 1'b1;
                    load_stall           = 1'b1;
                    if (stall_cnt_q <= 3'd1) begin
                        state_d     = HZ_ST_RUN;
                        stall_cnt_d = 3'd0;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 3'd1;
                    end
                end
                HZ_ST_MC: begin
                    if (!ex_mc_done) begin
                        pc_en                 = 1'b0;
                        if_id_pipeline_en     = 1'b0;
                        id_ex_pipeline_en     = 1'b0;
                        ex_mem_pipeline_flush = 1'b1;
                        mc_stall              = 1'b1;
                    end else begin
                        state_d = HZ_ST_RUN;
                    end
                end
                default: begin
                    state_d     = HZ_ST_RUN;
                    stall_cnt_d = 3'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_stall_cyc <= '0;
            perf_mc_stall_cyc   <= '0;
            perf_flush_cnt      <= '0;
        end else begin
            if (load_stall)
                perf_load_stall_cyc <= perf_load_stall_cyc + 1'b1;
            if (mc_stall)
                perf_mc_stall_cyc <= perf_mc_stall_cyc + 1'b1;
            if (jump_branch_taken)
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif

endmodule
